// File: rtl/reg_bus_initiator_if.sv
// rtl/reg_bus_initiator_if.sv - host command/response and register-bus signal bundle
//
// Groups the host command port (cmd_*), the host response port (rsp_*),
// the busy flag and the register request/response bus (reg_*).
//   master : the initiator side (accepts commands, drives reg_* requests,
//            returns responses)
//   slave  : the environment side (host plus peripheral register decoder)
interface reg_bus_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [10:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_be;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_wr;

    logic        busy;

    logic        reg_cs;
    logic        reg_wr;
    logic [10:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata;
    logic        reg_ack;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_be,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_wr,
        input  rsp_ready,
        output busy,
        output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        input  reg_rdata, reg_ack
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_be,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_wr,
        output rsp_ready,
        input  busy,
        input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        output reg_rdata, reg_ack
    );
endinterface

// File: rtl/reg_bus_initiator.sv
// rtl/reg_bus_initiator.sv - queued register-bus initiator with access timeout
//
// Host commands are queued in a CMD_DEPTH-entry FIFO and issued one at a
// time on the reg_* bus. Each access holds reg_cs until reg_ack or until
// TIMEOUT_CYC cycles have elapsed (0 disables the timeout); the result is
// held on rsp_* until the host accepts it.
// Ports:
//   mclk      - clock, all logic on posedge
//   h_reset_n - synchronous active-low reset
//   bus       - reg_bus_initiator_if.master: cmd_*, rsp_*, busy, reg_*
module reg_bus_initiator #(
    parameter int CMD_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   mclk,
    input  logic                   h_reset_n,
    reg_bus_initiator_if.master    bus
);
    localparam int AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYC != 0);
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [CW-1:0] FULL_CNT = CW'(CMD_DEPTH);

    typedef struct packed {
        logic        wr;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state;
    cmd_t            mem [CMD_DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [TW-1:0]   timer;
    logic            push;
    logic            pop;
    cmd_t            head;

    // cmd_ready is a register, so a push can never land on a full FIFO.
    assign push = bus.cmd_valid & bus.cmd_ready;
    assign pop  = (state == IDLE) && (count != '0);
    assign head = mem[rptr];

    always_comb begin
        count_next = count + CW'(push) - CW'(pop);
    end

    assign bus.busy = (state != IDLE) || (count != '0);

    // Storage needs no reset: entries are only read behind a non-zero count.
    always_ff @(posedge mclk) begin
        if (push) begin
            mem[wptr] <= '{wr: bus.cmd_wr, addr: bus.cmd_addr,
                           wdata: bus.cmd_wdata, be: bus.cmd_be};
        end
    end

    always_ff @(posedge mclk) begin
        if (!h_reset_n) begin
            state         <= IDLE;
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            timer         <= '0;
            bus.cmd_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_wr    <= 1'b0;
            bus.reg_cs    <= 1'b0;
            bus.reg_wr    <= 1'b0;
            bus.reg_addr  <= '0;
            bus.reg_wdata <= '0;
            bus.reg_be    <= '0;
        end else begin
            count         <= count_next;
            // Computed from the next count so ready drops in the same cycle
            // the FIFO becomes full, and rises the cycle after release.
            bus.cmd_ready <= (count_next != FULL_CNT);
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;

            case (state)
                IDLE: begin
                    if (count != '0) begin
                        bus.reg_wr    <= head.wr;
                        bus.reg_addr  <= head.addr;
                        bus.reg_wdata <= head.wdata;
                        bus.reg_be    <= head.be;
                        bus.reg_cs    <= 1'b1;
                        timer         <= '0;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (bus.reg_ack) begin
                        bus.rsp_rdata <= bus.reg_wr ? 32'd0 : bus.reg_rdata;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_wr    <= bus.reg_wr;
                        bus.rsp_valid <= 1'b1;
                        bus.reg_cs    <= 1'b0;
                        state         <= RESP;
                    end else if (TMO_EN && (timer == TIMER_LAST)) begin
                        // Timer counts from 0, so reg_cs has been high for
                        // exactly TIMEOUT_CYC cycles at this point.
                        bus.rsp_rdata <= 32'd0;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_wr    <= bus.reg_wr;
                        bus.rsp_valid <= 1'b1;
                        bus.reg_cs    <= 1'b0;
                        state         <= RESP;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    // reg_ack is not looked at here: a late ack is dropped.
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_bus_initiator.sv
// tb/tb_reg_bus_initiator.sv - self-checking bench for reg_bus_initiator
module tb_reg_bus_initiator;
    logic mclk = 1'b0;
    logic h_reset_n = 1'b0;

    always #5 mclk = ~mclk;

    reg_bus_initiator_if bus();

    reg_bus_initiator #(
        .CMD_DEPTH   (4),
        .TIMEOUT_CYC (255)
    ) dut (
        .mclk      (mclk),
        .h_reset_n (h_reset_n),
        .bus       (bus)
    );

    typedef struct {
        logic        wr;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        logic        wr;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];

    int compared   = 0;
    int mismatched = 0;

    int   ack_delay = 0;
    logic inj_ack   = 1'b0;
    int   cs_cnt    = 0;

    int          cs_run      = 0;
    int          low_run     = 0;
    int          last_cs_len = 0;
    int          cs_rises    = 0;
    int          cs_falls    = 0;
    int          rsp_cnt     = 0;
    bit          had_access  = 1'b0;
    bit          prev_cs     = 1'b0;
    bit          stab_bad    = 1'b0;
    logic [47:0] cur_req     = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dec_data(input logic [10:0] a);
        return 32'hA5A5_0000 | {27'd0, a[10:6]};
    endfunction

    // Decoder model: acks ack_delay cycles after reg_cs rises (-1 = never).
    initial begin
        bus.reg_ack   = 1'b0;
        bus.reg_rdata = 32'd0;
        forever begin
            @(negedge mclk);
            #1;
            if (bus.reg_cs === 1'b1) cs_cnt++;
            else                     cs_cnt = 0;
            if ((ack_delay >= 0 && cs_cnt == ack_delay + 1) || inj_ack) begin
                bus.reg_ack   = 1'b1;
                bus.reg_rdata = dec_data(bus.reg_addr);
            end else begin
                bus.reg_ack   = 1'b0;
                bus.reg_rdata = 32'hDEAD_BEEF;
            end
        end
    end

    // Monitor: request order/stability, cs gaps, response scoreboard.
    initial begin
        req_t r;
        rsp_t e;
        forever begin
            @(negedge mclk);
            #2;
            if (bus.reg_cs === 1'b1 && !prev_cs) begin
                cs_rises++;
                if (had_access) check("cs_low_gap_ge2", 64'(low_run >= 2), 64'(1));
                if (req_q.size() == 0) begin
                    check("req_unexpected", 64'(1), 64'(0));
                end else begin
                    r = req_q.pop_front();
                    check("req_fields",
                          64'({bus.reg_wr, bus.reg_addr, bus.reg_wdata, bus.reg_be}),
                          64'({r.wr, r.addr, r.wdata, r.be}));
                end
                cur_req  = {bus.reg_wr, bus.reg_addr, bus.reg_wdata, bus.reg_be};
                cs_run   = 0;
                stab_bad = 1'b0;
            end
            if (bus.reg_cs === 1'b1) begin
                cs_run++;
                if ({bus.reg_wr, bus.reg_addr, bus.reg_wdata, bus.reg_be} !== cur_req)
                    stab_bad = 1'b1;
            end else begin
                if (prev_cs) begin
                    last_cs_len = cs_run;
                    cs_falls++;
                    had_access  = 1'b1;
                    low_run     = 0;
                    check("req_stable", 64'(stab_bad), 64'(0));
                end
                low_run++;
            end
            if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                rsp_cnt++;
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(1), 64'(0));
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp_fields",
                          64'({bus.rsp_wr, bus.rsp_err, bus.rsp_rdata}),
                          64'({e.wr, e.err, e.rdata}));
                end
            end
            prev_cs = (bus.reg_cs === 1'b1);
        end
    end

    // Called at a negedge; returns at a negedge with cmd_valid low.
    task automatic send(input logic wr, input logic [10:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic err, input int max_wait,
                        output bit acc);
        req_t r;
        rsp_t e;
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_be    = be;
        acc = 1'b0;
        for (int i = 0; i < max_wait && !acc; i++) begin
            #2;
            if (bus.cmd_ready === 1'b1) begin
                acc = 1'b1;
                r = '{wr: wr, addr: addr, wdata: wdata, be: be};
                e = '{wr: wr, err: err, rdata: (wr || err) ? 32'd0 : dec_data(addr)};
                req_q.push_back(r);
                rsp_q.push_back(e);
            end
            @(negedge mclk);
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int max_cyc, input string tag);
        int n = 0;
        while (rsp_cnt < target && n < max_cyc) begin
            @(negedge mclk);
            n++;
        end
        check(tag, 64'(rsp_cnt >= target), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        int n_acc;
        int base;
        int falls0;
        int rises0;
        int n;

        bus.cmd_valid = 1'b0;
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_be    = '0;
        bus.rsp_ready = 1'b1;
        h_reset_n     = 1'b0;

        repeat (3) @(negedge mclk);
        #2;
        check("reset_ctrl", 64'({bus.reg_cs, bus.rsp_valid, bus.busy, bus.cmd_ready,
                                 bus.rsp_err, bus.rsp_wr, bus.reg_wr}), 64'(0));
        check("reset_rdata", 64'(bus.rsp_rdata), 64'(0));
        @(negedge mclk);
        h_reset_n = 1'b1;
        @(negedge mclk);
        #2;
        check("ready_after_release", 64'(bus.cmd_ready), 64'(1));
        @(negedge mclk);

        // 1: write, ack 2 cycles after cs rises -> cs high 3 cycles
        ack_delay = 2;
        send(1'b1, 11'h004, 32'h1234_5678, 4'hF, 1'b0, 5, acc);
        check("t1_accepted", 64'(acc), 64'(1));
        wait_rsp(1, 50, "t1_rsp_seen");
        check("t1_cs_len", 64'(last_cs_len), 64'(3));

        // 2: read, ack on first cs cycle
        ack_delay = 0;
        send(1'b0, 11'h044, 32'h0, 4'hF, 1'b0, 5, acc);
        wait_rsp(2, 50, "t2_rsp_seen");
        check("t2_cs_len", 64'(last_cs_len), 64'(1));

        // 3: timeout, late ack while response is pending, then normal access
        ack_delay = -1;
        bus.rsp_ready = 1'b0;
        falls0 = cs_falls;
        send(1'b0, 11'h0C8, 32'h0, 4'h3, 1'b1, 5, acc);
        n = 0;
        while (cs_falls == falls0 && n < 400) begin
            @(negedge mclk);
            n++;
        end
        check("t3_cs_fell", 64'(cs_falls != falls0), 64'(1));
        check("t3_cs_len", 64'(last_cs_len), 64'(255));
        repeat (3) @(negedge mclk);
        inj_ack = 1'b1;
        @(negedge mclk);
        inj_ack = 1'b0;
        #2;
        check("t3_rsp_held", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}),
              64'({1'b1, 1'b1, 32'd0}));
        @(negedge mclk);
        bus.rsp_ready = 1'b1;
        wait_rsp(3, 20, "t3_rsp_seen");
        ack_delay = 1;
        send(1'b0, 11'h104, 32'h0, 4'hF, 1'b0, 5, acc);
        wait_rsp(4, 50, "t3_next_rsp_seen");
        check("t3_next_cs_len", 64'(last_cs_len), 64'(2));

        // 4: six back-to-back commands with responses blocked
        ack_delay = 0;
        bus.rsp_ready = 1'b0;
        base  = rsp_cnt;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(1'(i % 2), 11'(i * 68), 32'h1000_0000 + 32'(i), 4'(i + 1), 1'b0,
                 (i < 5) ? 4 : 3, acc);
            n_acc += int'(acc);
        end
        check("t4_accepted", 64'(n_acc), 64'(5));
        #2;
        check("t4_ready_low", 64'(bus.cmd_ready), 64'(0));
        @(negedge mclk);
        bus.rsp_ready = 1'b1;
        wait_rsp(base + 5, 200, "t4_drain");
        #2;
        check("t4_idle_busy", 64'(bus.busy), 64'(0));
        @(negedge mclk);

        // 5: reset during an access with two commands queued
        ack_delay = -1;
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 11'(12'h200 + i * 4), 32'hCAFE_0000 + 32'(i), 4'hF, 1'b1, 4, acc);
        end
        repeat (5) @(negedge mclk);
        #2;
        check("t5_in_access", 64'({bus.reg_cs, bus.busy}), 64'({1'b1, 1'b1}));
        @(negedge mclk);
        h_reset_n = 1'b0;
        @(negedge mclk);
        #2;
        check("t5_reset_outputs", 64'({bus.reg_cs, bus.rsp_valid, bus.busy}), 64'(0));
        req_q.delete();
        rsp_q.delete();
        @(negedge mclk);
        h_reset_n = 1'b1;
        @(negedge mclk);
        #2;
        check("t5_ready_after_release", 64'(bus.cmd_ready), 64'(1));
        had_access = 1'b0;
        rises0 = cs_rises;
        repeat (20) @(negedge mclk);
        check("t5_no_access", 64'(cs_rises), 64'(rises0));
        check("t5_busy_low", 64'(bus.busy), 64'(0));

        ack_delay = 0;
        base = rsp_cnt;
        send(1'b0, 11'h3C0, 32'h0, 4'hF, 1'b0, 5, acc);
        wait_rsp(base + 1, 50, "t5_post_reset_rsp");
        check("queues_drained", 64'(req_q.size() + rsp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
